// File: rtl/vga_pkg.sv
// Shared SVGA timing constants, coordinate types and the timing bundle
// consumed by the renderer and screen logic.
package vga_pkg;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned FRAME_W   = 16;
    localparam int unsigned COORD_MAX = (1 << COORD_W) - 1;

    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SYNC   = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SYNC   = 4;
    localparam int unsigned SVGA_V_BP     = 23;
    localparam int unsigned SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FRAME_W-1:0] frame_t;

    typedef struct packed {
        coord_t hcount;
        coord_t vcount;
        logic   hsync;
        logic   vsync;
        logic   hblnk;
        logic   vblnk;
        logic   line_start;
        logic   frame_start;
    } vga_timing_t;

    // True when lo <= c < lo+len.
    function automatic logic in_window(coord_t c, int unsigned lo, int unsigned len);
        return (32'(c) >= lo) && (32'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the generator drives it (master), renderers and
// screen logic read it (slave).
interface vga_timing_gen_if;

    logic [vga_pkg::COORD_W-1:0] hcount;
    logic [vga_pkg::COORD_W-1:0] vcount;
    logic                        hsync;
    logic                        vsync;
    logic                        hblnk;
    logic                        vblnk;
    logic                        line_start;
    logic                        frame_start;
    logic [vga_pkg::FRAME_W-1:0] frame_cnt;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk,
               line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_pipe_delay.sv
// Enable-gated shift register of DEPTH stages; every stage resets
// asynchronously to RST_VAL.
module vga_pipe_delay #(
    parameter int unsigned       WIDTH   = 1,
    parameter int unsigned       DEPTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_ss,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_pipe_delay: DEPTH must be at least 1");
    end

    localparam int unsigned SR_W = DEPTH * WIDTH;
    typedef logic [SR_W-1:0] sr_t;

    sr_t sr_q;

    // New samples enter at the low end; the oldest stage sits at the top.
    always_ff @(posedge clk_ss or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= {DEPTH{RST_VAL}};
        end else if (en) begin
            sr_q <= sr_t'({sr_q, din});
        end
    end

    assign dout = sr_q[SR_W-1 -: WIDTH];

endmodule

// File: rtl/vga_timing_gen.sv
// SVGA raster timing generator: pixel/line counters, sync and blank decodes,
// line/frame markers and frame counter, with an optional output delay line.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = SVGA_H_ACTIVE,
    parameter int unsigned H_FP       = SVGA_H_FP,
    parameter int unsigned H_SYNC     = SVGA_H_SYNC,
    parameter int unsigned H_BP       = SVGA_H_BP,
    parameter int unsigned V_ACTIVE   = SVGA_V_ACTIVE,
    parameter int unsigned V_FP       = SVGA_V_FP,
    parameter int unsigned V_SYNC     = SVGA_V_SYNC,
    parameter int unsigned V_BP       = SVGA_V_BP,
    parameter int unsigned SYNC_POL   = 1,
    parameter int unsigned PIPE_DELAY = 0
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              en,
    vga_timing_gen_if.master  tim
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam coord_t      H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t      V_LAST       = coord_t'(V_TOTAL - 1);
    localparam logic        SYNC_ON      = (SYNC_POL != 0);
    localparam int unsigned TIM_W        = $bits(vga_timing_t);
    localparam int unsigned PIPE_W       = FRAME_W + TIM_W;

    localparam vga_timing_t TIM_RST = '{
        hcount:      '0,
        vcount:      '0,
        hsync:       ~SYNC_ON,
        vsync:       ~SYNC_ON,
        hblnk:       1'b0,
        vblnk:       1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
    end
    if (PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    vga_timing_t cur_q;
    vga_timing_t nxt;
    frame_t      f_q;
    frame_t      f_nxt;
    coord_t      h_nxt;
    coord_t      v_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic        stalled_q;

    always_comb begin
        h_wrap = (cur_q.hcount == H_LAST);
        v_wrap = (cur_q.vcount == V_LAST);
        h_nxt  = h_wrap ? '0 : cur_q.hcount + coord_t'(1);
        v_nxt  = cur_q.vcount;
        f_nxt  = f_q;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : cur_q.vcount + coord_t'(1);
            if (v_wrap) begin
                f_nxt = f_q + frame_t'(1);
            end
        end
        nxt = '{
            hcount:      h_nxt,
            vcount:      v_nxt,
            hsync:       in_window(h_nxt, H_SYNC_START, H_SYNC) ^ ~SYNC_ON,
            vsync:       in_window(v_nxt, V_SYNC_START, V_SYNC) ^ ~SYNC_ON,
            hblnk:       (32'(h_nxt) >= H_ACTIVE),
            vblnk:       (32'(v_nxt) >= V_ACTIVE),
            line_start:  h_wrap,
            frame_start: h_wrap && v_wrap
        };
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q     <= TIM_RST;
            f_q       <= '0;
            stalled_q <= 1'b0;
        end else begin
            stalled_q <= ~en;
            if (en) begin
                cur_q <= nxt;
                f_q   <= f_nxt;
            end
        end
    end

    logic [PIPE_W-1:0] pipe_in;
    logic [PIPE_W-1:0] pipe_out;
    vga_timing_t       out_tim;

    assign pipe_in = {f_q, cur_q};

    if (PIPE_DELAY == 0) begin : g_nodelay
        assign pipe_out = pipe_in;
    end else begin : g_delay
        localparam logic [PIPE_W-1:0] PIPE_RST = {frame_t'(0), TIM_RST};

        vga_pipe_delay #(
            .WIDTH   (PIPE_W),
            .DEPTH   (PIPE_DELAY),
            .RST_VAL (PIPE_RST)
        ) u_pipe (
            .clk_ss  (pclk),
            .reset_n (reset_n),
            .en      (en),
            .din     (pipe_in),
            .dout    (pipe_out)
        );
    end

    assign out_tim = pipe_out[TIM_W-1:0];

    // Pulses stay held in the core/pipe across a stall so the delay line never
    // loses one; they are masked at the output on every stalled cycle instead.
    assign tim.hcount      = out_tim.hcount;
    assign tim.vcount      = out_tim.vcount;
    assign tim.hsync       = out_tim.hsync;
    assign tim.vsync       = out_tim.vsync;
    assign tim.hblnk       = out_tim.hblnk;
    assign tim.vblnk       = out_tim.vblnk;
    assign tim.line_start  = out_tim.line_start  & ~stalled_q;
    assign tim.frame_start = out_tim.frame_start & ~stalled_q;
    assign tim.frame_cnt   = pipe_out[PIPE_W-1:TIM_W];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full SVGA instance plus small-raster
// instances for frame-level, delay-line and inverted-sync behaviour.
module tb_vga_timing_gen;

    localparam int SH_A  = 8;
    localparam int SH_FP = 2;
    localparam int SH_S  = 3;
    localparam int SH_BP = 3;
    localparam int SV_A  = 6;
    localparam int SV_FP = 1;
    localparam int SV_S  = 2;
    localparam int SV_BP = 1;

    logic pclk    = 1'b0;
    logic reset_n = 1'b0;
    logic en      = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen_if if_big ();
    vga_timing_gen_if if_sm  ();
    vga_timing_gen_if if_dly ();
    vga_timing_gen_if if_neg ();

    vga_timing_gen u_big (
        .pclk(pclk), .reset_n(reset_n), .en(en), .tim(if_big)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
        .SYNC_POL(1), .PIPE_DELAY(0)
    ) u_sm (
        .pclk(pclk), .reset_n(reset_n), .en(en), .tim(if_sm)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
        .SYNC_POL(1), .PIPE_DELAY(3)
    ) u_dly (
        .pclk(pclk), .reset_n(reset_n), .en(en), .tim(if_dly)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
        .SYNC_POL(0), .PIPE_DELAY(0)
    ) u_neg (
        .pclk(pclk), .reset_n(reset_n), .en(en), .tim(if_neg)
    );

    logic [43:0] o_big, o_sm, o_dly, o_neg;
    assign o_big = {if_big.hcount, if_big.vcount, if_big.hsync, if_big.vsync, if_big.hblnk,
                    if_big.vblnk, if_big.line_start, if_big.frame_start, if_big.frame_cnt};
    assign o_sm  = {if_sm.hcount, if_sm.vcount, if_sm.hsync, if_sm.vsync, if_sm.hblnk,
                    if_sm.vblnk, if_sm.line_start, if_sm.frame_start, if_sm.frame_cnt};
    assign o_dly = {if_dly.hcount, if_dly.vcount, if_dly.hsync, if_dly.vsync, if_dly.hblnk,
                    if_dly.vblnk, if_dly.line_start, if_dly.frame_start, if_dly.frame_cnt};
    assign o_neg = {if_neg.hcount, if_neg.vcount, if_neg.hsync, if_neg.vsync, if_neg.hblnk,
                    if_neg.vblnk, if_neg.line_start, if_neg.frame_start, if_neg.frame_cnt};

    typedef struct {
        int h;
        int v;
        int f;
        bit ls;
        bit fs;
    } mdl_t;

    mdl_t mb;
    mdl_t ms;
    mdl_t hist[$];
    bit   stalled;

    function automatic mdl_t mdl_step(mdl_t m, int ht, int vt);
        mdl_t r;
        r    = m;
        r.ls = 1'b0;
        r.fs = 1'b0;
        if (m.h == ht - 1) begin
            r.h  = 0;
            r.ls = 1'b1;
            if (m.v == vt - 1) begin
                r.v  = 0;
                r.fs = 1'b1;
                r.f  = (m.f + 1) % 65536;
            end else begin
                r.v = m.v + 1;
            end
        end else begin
            r.h = m.h + 1;
        end
        return r;
    endfunction

    function automatic logic [43:0] mdl_vec(mdl_t m, int ha, int hfp, int hs,
                                            int va, int vfp, int vs, bit pol, bit stl);
        bit hsa;
        bit vsa;
        hsa = (m.h >= ha + hfp) && (m.h < ha + hfp + hs);
        vsa = (m.v >= va + vfp) && (m.v < va + vfp + vs);
        return {11'(m.h), 11'(m.v), (pol ? hsa : !hsa), (pol ? vsa : !vsa),
                (m.h >= ha), (m.v >= va), (m.ls && !stl), (m.fs && !stl), 16'(m.f)};
    endfunction

    task automatic check_vec(string tag, logic [43:0] obs, logic [43:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        mb      = '{h: 0, v: 0, f: 0, ls: 1'b0, fs: 1'b0};
        ms      = mb;
        stalled = 1'b0;
        hist.delete();
        repeat (4) hist.push_back(ms);
    endtask

    task automatic check_all(string tag);
        check_vec({tag, ".big"}, o_big, mdl_vec(mb, 800, 40, 128, 600, 1, 4, 1'b1, stalled));
        check_vec({tag, ".sm"},  o_sm,  mdl_vec(ms, SH_A, SH_FP, SH_S, SV_A, SV_FP, SV_S, 1'b1, stalled));
        check_vec({tag, ".neg"}, o_neg, mdl_vec(ms, SH_A, SH_FP, SH_S, SV_A, SV_FP, SV_S, 1'b0, stalled));
        check_vec({tag, ".dly"}, o_dly, mdl_vec(hist[0], SH_A, SH_FP, SH_S, SV_A, SV_FP, SV_S, 1'b1, stalled));
    endtask

    // Advance one clock; the model follows the enable seen at the edge.
    task automatic tick();
        @(posedge pclk);
        if (reset_n && en) begin
            stalled = 1'b0;
            mb = mdl_step(mb, 1056, 628);
            ms = mdl_step(ms, 16, 10);
            hist.push_back(ms);
            void'(hist.pop_front());
        end else if (reset_n) begin
            stalled = 1'b1;
        end
        #1;
    endtask

    int hs_cnt, hb_cnt, ls_cnt, fs_sm_cnt, vs_sm_cnt, fs_big_cnt;

    initial begin
        reset_model();
        repeat (3) @(posedge pclk);
        #1;
        check_all("reset");
        check_int("reset_big_hsync", int'(if_big.hsync), 0);
        check_int("reset_neg_hsync", int'(if_neg.hsync), 1);
        check_int("reset_neg_vsync", int'(if_neg.vsync), 1);

        // One full SVGA line plus two pixels
        reset_n = 1'b1;
        en      = 1'b1;
        hs_cnt = 0; hb_cnt = 0; ls_cnt = 0; fs_sm_cnt = 0; vs_sm_cnt = 0;
        for (int i = 0; i < 1058; i++) begin
            tick();
            check_all("line");
            if (if_big.hsync)      hs_cnt++;
            if (if_big.hblnk)      hb_cnt++;
            if (if_sm.frame_start) fs_sm_cnt++;
            if (if_sm.vsync)       vs_sm_cnt++;
            if (if_big.line_start) begin
                ls_cnt++;
                check_int("ls_at_h0", int'(if_big.hcount), 0);
            end
            if (i == 0)   check_int("first_h", int'(if_big.hcount), 1);
            if (i == 1055) begin
                check_int("wrap_h",  int'(if_big.hcount), 0);
                check_int("wrap_v",  int'(if_big.vcount), 1);
                check_int("wrap_ls", int'(if_big.line_start), 1);
            end
            if (i == 159) begin
                check_int("sm_first_fs",  int'(if_sm.frame_start), 1);
                check_int("sm_fs_with_ls", int'(if_sm.line_start), 1);
                check_int("sm_first_fcnt", int'(if_sm.frame_cnt), 1);
            end
        end
        check_int("hsync_cycles", hs_cnt, 128);
        check_int("hblnk_cycles", hb_cnt, 256);
        check_int("ls_count", ls_cnt, 1);
        check_int("sm_fs_count", fs_sm_cnt, 6);
        check_int("sm_vsync_cycles", vs_sm_cnt, 192);
        check_int("sm_fcnt", int'(if_sm.frame_cnt), 6);

        // Stall for five cycles on the last pixel of line 1
        for (int i = 0; i < 2000 && mb.h != 1055; i++) begin
            tick();
            check_all("adv1");
        end
        check_int("at_1055", int'(if_big.hcount), 1055);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("stall");
            check_int("stall_h",  int'(if_big.hcount), 1055);
            check_int("stall_ls", int'(if_big.line_start), 0);
        end
        en = 1'b1;
        tick();
        check_all("resume");
        check_int("resume_h",  int'(if_big.hcount), 0);
        check_int("resume_v",  int'(if_big.vcount), 2);
        check_int("resume_ls", int'(if_big.line_start), 1);
        tick();
        check_all("resume2");
        check_int("ls_once", int'(if_big.line_start), 0);

        // Asynchronous reset in the middle of the hsync window
        for (int i = 0; i < 2000 && mb.h != 900; i++) begin
            tick();
            check_all("adv2");
        end
        check_int("pre_rst_h", int'(if_big.hcount), 900);
        check_int("pre_rst_hsync", int'(if_big.hsync), 1);
        #2;
        reset_n = 1'b0;
        #1;
        reset_model();
        check_all("async_rst");
        check_int("rst_h", int'(if_big.hcount), 0);
        check_int("rst_hsync", int'(if_big.hsync), 0);
        check_int("rst_neg_hsync", int'(if_neg.hsync), 1);
        tick();
        check_all("rst_held");
        reset_n = 1'b1;

        fs_sm_cnt  = 0;
        fs_big_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            check_all("restart");
            if (if_sm.frame_start)  fs_sm_cnt++;
            if (if_big.frame_start) fs_big_cnt++;
            if (i == 0) begin
                check_int("restart_h",  int'(if_big.hcount), 1);
                check_int("restart_fs", int'(if_sm.frame_start), 0);
            end
            if (i == 158) check_int("sm_no_early_fs", int'(if_sm.frame_start), 0);
            if (i == 159) check_int("sm_fs_full_frame", int'(if_sm.frame_start), 1);
        end
        check_int("restart_sm_fs_count", fs_sm_cnt, 1);
        check_int("restart_big_fs_count", fs_big_cnt, 0);
        check_int("restart_big_fcnt", int'(if_big.frame_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
